layer_write_sequencer: RTL and testbench
========================================

Name: layer_write_sequencer

Overview:
- Transmit end of the layer write interface: turns a flat valid/ready stream of DATA_SIZE-bit words (IEEE-754 doubles) into indexed write strobes for a layer's weight or activation store.
- Sits between the host/testbench data source and the layer's write port (write_data, in_index3..0, want_write_weights, want_write_act).
- Generates the 4-level index odometer, so the host supplies data words only, in a fixed order.

Parameters:
- DATA_SIZE, 64, width of one data word (double precision bits).
- NUM_INPUTS, 1, input channels of the target layer.
- NUM_OUTPUTS, 16, output channels (kernels) of the target layer.
- KERNEL_DIM, 3, kernel side length.
- INPUT_DIM, 28, activation map side length.
- IDX_W, 16, width of each index output.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a load sequence; sampled only in IDLE.
- mode  input  1  0 = weights, 1 = activations; latched on accepted start.
- in_data  input  DATA_SIZE  stream word.
- in_valid  input  1  stream word valid.
- in_ready  output  1  sequencer accepts word this cycle.
- write_data  output  DATA_SIZE  word to layer.
- index3, index2, index1, index0  output  IDX_W each  target coordinate.
- write_weights  output  1  one-cycle weight write strobe.
- write_act  output  1  one-cycle activation write strobe.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after last write.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; counters 0; latched mode 0. Takes effect immediately mid-sequence; a partial load is abandoned, with no further strobes.
- FSM: IDLE -> LOAD on start; LOAD -> FIN on last word accepted; FIN -> IDLE unconditionally after one cycle.
- IDLE: in_ready=0, busy=0. start=1 latches mode, clears counters c3..c0, enters LOAD. start is ignored outside IDLE.
- LOAD: in_ready=1, busy=1. Word accepted when in_valid&&in_ready. No acceptance means no strobe and counters hold. Bubbles are allowed.
- Output latency: 1 cycle, all outputs registered. In the cycle after acceptance:
  - write_data = accepted word;
  - indexN = counter values at acceptance;
  - exactly one of write_weights / write_act is high, chosen by latched mode.
  - Between strobes, data and indices hold their last value.
- Weights order (mode 0): c3 = output ch 0..NUM_OUTPUTS-1 (slowest), c2 = input ch 0..NUM_INPUTS-1, c1 = row 0..KERNEL_DIM-1, c0 = col 0..KERNEL_DIM-1 (fastest). Total NUM_OUTPUTS*NUM_INPUTS*KERNEL_DIM^2 = 144 by default.
- Activations order (mode 1): c3 held 0, c2 = input ch, c1 = row 0..INPUT_DIM-1, c0 = col 0..INPUT_DIM-1. Total NUM_INPUTS*INPUT_DIM^2 = 784 by default.
- Odometer: c0 increments per accept. On reaching its limit-1, c0 wraps to 0 and carries into c1, which carries into c2, then c3, using mode-dependent limits.
- Last word: all counters at limit-1. On acceptance, in_ready drops the next cycle (state FIN), so no extra word is taken.
- FIN: the final strobe is asserted this cycle. done=1 for exactly this cycle, busy=1, and the final strobe coincides with done. Next cycle: IDLE, busy=0.
- start high in FIN or LOAD: ignored. start held high continuously re-arms in the first IDLE cycle after FIN.
- Index outputs are zero-extended to IDX_W. Limits are compile-time; each limit must be at most 2^IDX_W.

Decomposition:
- Shared package (dnn_pkg): state enum {IDLE, LOAD, FIN}, MODE_WEIGHTS=0 / MODE_ACT=1 constants, default DATA_SIZE.
- One sub-module: index_odometer, holding 4 counters with per-digit limit inputs, an inc input, and a last output. Reused by the output-side collector.

Test Plan:
- Weights load: start, mode=0, 144 back-to-back words value k as $realtobits(k) -> 144 write_weights pulses. Word k at index (k/9, 0, (k%9)/3, k%3); word 143 at (15,0,2,2); done coincides with last strobe; write_act never high.
- Activation load, mode=1, 784 words -> word 29 at (0,0,1,1); word 783 at (0,0,27,27); done after 784 strobes; write_weights never high.
- Bubbles: in_valid toggling 1,0,0,1 -> strobes only the cycle after each acceptance; indices advance only on accepts; total strobes still equal word count.
- start while busy at word 50 -> ignored, sequence completes normally at 144; start held through FIN -> new sequence begins the cycle after returning to IDLE.
- rst_n low at word 70 of a weights load -> in the same cycle: in_ready, strobes, busy=0, indices 0. After release, a new start restarts at (0,0,0,0).
- Extra word: in_valid held high after word 143 -> in_ready=0 from FIN onward, and no 145th strobe.

Source files
------------

// File: rtl/dnn_pkg.sv
// Types and constants shared by the layer write-side blocks.
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic MODE_WEIGHTS      = 1'b0;
    localparam logic MODE_ACT          = 1'b1;
    localparam int   DEFAULT_DATA_SIZE = 64;
    localparam int   NUM_DIGITS        = 4;

endpackage

// File: rtl/index_odometer.sv
// Four-digit mixed-radix counter; digit 0 is fastest, each digit wraps at its own limit.
module index_odometer
    import dnn_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic                                  inc,
    input  logic [NUM_DIGITS-1:0][IDX_W:0]        limit,
    output logic [NUM_DIGITS-1:0][IDX_W-1:0]      count,
    output logic                                  last
);

    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] carry;

    assign carry[0] = inc;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [IDX_W-1:0] count_reg;

            // Limits are one bit wider so a full 2^IDX_W range is expressible.
            assign at_max[gi] = ({1'b0, count_reg} == (limit[gi] - (IDX_W + 1)'(1)));
            assign count[gi]  = count_reg;

            if (gi < NUM_DIGITS - 1) begin : g_carry
                assign carry[gi + 1] = carry[gi] & at_max[gi];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (carry[gi]) begin
                    count_reg <= at_max[gi] ? '0 : count_reg + IDX_W'(1);
                end
            end
        end
    endgenerate

    assign last = &at_max;

endmodule

// File: rtl/layer_write_sequencer.sv
// Turns a flat valid/ready word stream into indexed weight or activation write strobes.
module layer_write_sequencer
    import dnn_pkg::*;
#(
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 16,
    parameter int KERNEL_DIM  = 3,
    parameter int INPUT_DIM   = 28,
    parameter int IDX_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] write_data,
    output logic [IDX_W-1:0]     index3,
    output logic [IDX_W-1:0]     index2,
    output logic [IDX_W-1:0]     index1,
    output logic [IDX_W-1:0]     index0,
    output logic                 write_weights,
    output logic                 write_act,
    output logic                 busy,
    output logic                 done
);

    localparam int LIM_W = IDX_W + 1;

    state_t                              state_reg;
    logic                                mode_reg;
    logic                                accept;
    logic                                odo_clear;
    logic                                odo_last;
    logic [NUM_DIGITS-1:0][IDX_W:0]      limit;
    logic [NUM_DIGITS-1:0][IDX_W-1:0]    count;

    assign accept    = in_valid && in_ready;
    assign odo_clear = (state_reg == IDLE) && start;

    always_comb begin
        if (mode_reg == MODE_WEIGHTS) begin
            limit[3] = LIM_W'(NUM_OUTPUTS);
            limit[2] = LIM_W'(NUM_INPUTS);
            limit[1] = LIM_W'(KERNEL_DIM);
            limit[0] = LIM_W'(KERNEL_DIM);
        end else begin
            limit[3] = LIM_W'(1);
            limit[2] = LIM_W'(NUM_INPUTS);
            limit[1] = LIM_W'(INPUT_DIM);
            limit[0] = LIM_W'(INPUT_DIM);
        end
    end

    index_odometer #(
        .IDX_W(IDX_W)
    ) u_odometer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (odo_clear),
        .inc   (accept),
        .limit (limit),
        .count (count),
        .last  (odo_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_WEIGHTS;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            write_weights <= 1'b0;
            write_act     <= 1'b0;
            write_data    <= '0;
            index3        <= '0;
            index2        <= '0;
            index1        <= '0;
            index0        <= '0;
        end else begin
            write_weights <= 1'b0;
            write_act     <= 1'b0;
            done          <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg  <= mode;
                        state_reg <= LOAD;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        write_data    <= in_data;
                        index3        <= count[3];
                        index2        <= count[2];
                        index1        <= count[1];
                        index0        <= count[0];
                        write_weights <= (mode_reg == MODE_WEIGHTS);
                        write_act     <= (mode_reg == MODE_ACT);
                        // Final strobe and done land together in the FIN cycle.
                        if (odo_last) begin
                            state_reg <= FIN;
                            in_ready  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_write_sequencer.sv
// Scoreboard bench: driver pushes model-predicted writes on acceptance, monitor pops on each strobe.
module tb_layer_write_sequencer;

    localparam int DS = 64;
    localparam int NI = 1;
    localparam int NO = 16;
    localparam int KD = 3;
    localparam int ID = 28;
    localparam int IW = 16;
    localparam int N_W = NO * NI * KD * KD;
    localparam int N_A = NI * ID * ID;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [DS-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DS-1:0] write_data;
    logic [IW-1:0] index3, index2, index1, index0;
    logic          write_weights, write_act, busy, done;

    layer_write_sequencer #(
        .DATA_SIZE(DS), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO),
        .KERNEL_DIM(KD), .INPUT_DIM(ID), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .write_data(write_data), .index3(index3), .index2(index2),
        .index1(index1), .index0(index0), .write_weights(write_weights),
        .write_act(write_act), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DS-1:0] data;
        int            i3, i2, i1, i0;
        logic          act;
        logic          last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    int   expected_strobes = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference: the coordinate of word k is its mixed-radix decomposition.
    function automatic exp_t model(input logic m, input int k, input int n, input logic [DS-1:0] d);
        exp_t e;
        e.data = d;
        e.act  = m;
        e.last = (k == n - 1);
        if (!m) begin
            e.i3 = k / (KD * KD * NI);
            e.i2 = (k / (KD * KD)) % NI;
            e.i1 = (k / KD) % KD;
            e.i0 = k % KD;
        end else begin
            e.i3 = 0;
            e.i2 = k / (ID * ID);
            e.i1 = (k / ID) % ID;
            e.i0 = k % ID;
        end
        return e;
    endfunction

    always begin
        @(negedge clk);
        if (rst_n) begin
            if (write_weights || write_act) begin
                strobes++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_strobe: got strobe w=%0b a=%0b expected none at %0t",
                             write_weights, write_act, $time);
                end else begin
                    mon_e = sb.pop_front();
                    $display("write data=%016h idx=(%0d,%0d,%0d,%0d) w=%0b a=%0b done=%0b",
                             write_data, index3, index2, index1, index0, write_weights, write_act, done);
                    chk("write_data", write_data, mon_e.data);
                    chk("index3", 64'(index3), 64'(mon_e.i3));
                    chk("index2", 64'(index2), 64'(mon_e.i2));
                    chk("index1", 64'(index1), 64'(mon_e.i1));
                    chk("index0", 64'(index0), 64'(mon_e.i0));
                    chk("write_act", 64'(write_act), 64'(mon_e.act));
                    chk("write_weights", 64'(write_weights), 64'(!mon_e.act));
                    chk("done", 64'(done), 64'(mon_e.last));
                end
            end else if (done) begin
                chk("done_without_strobe", 64'(done), 64'(0));
            end
        end
    end

    // vmode: 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random valid.
    task automatic load(input logic m, input int n, input int vmode, input int start_at,
                        input bit hold_start, input int reset_at, input bit rand_data);
        int            k = 0;
        int            cyc = 0;
        int            budget;
        logic          v;
        logic [DS-1:0] d;
        budget = n * 8 + 20;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        while (k < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (start_at >= 0 && k == start_at);
            if (reset_at >= 0 && k == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_in_ready", 64'(in_ready), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_strobes", 64'({write_weights, write_act}), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_indices", {index3, index2, index1, index0}, 64'(0));
                in_valid = 1'b0;
                start    = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                sb.delete();
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            d = rand_data ? {$urandom, $urandom} : $realtobits(real'(k));
            in_valid = v;
            in_data  = d;
            if (k > 0 && k < n) chk("busy_in_load", 64'(busy), 64'(1));
            if (v && in_ready) begin
                sb.push_back(model(m, k, n, d));
                expected_strobes++;
                k++;
            end
        end
        if (k < n) begin
            chk("load_timeout_words", 64'(k), 64'(n));
            in_valid = 1'b0;
            start = 1'b0;
            return;
        end
        // Keep offering words past the end: none may be taken.
        in_valid = 1'b1;
        start    = hold_start;
        @(negedge clk);
        chk("fin_in_ready", 64'(in_ready), 64'(0));
        chk("fin_busy", 64'(busy), 64'(1));
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("rearm_in_ready", 64'(in_ready), 64'(hold_start));
        chk("rearm_busy", 64'(busy), 64'(hold_start));
        in_valid = 1'b0;
        if (!hold_start) start = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_strobes", 64'({write_weights, write_act}), 64'(0));
        chk("reset_indices", {index3, index2, index1, index0}, 64'(0));
        chk("reset_data", write_data, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        load(1'b0, N_W, 0, -1, 1'b0, -1, 1'b0);
        load(1'b1, N_A, 0, -1, 1'b0, -1, 1'b0);
        load(1'b0, N_W, 1, -1, 1'b0, -1, 1'b0);
        load(1'b0, N_W, 0, 50, 1'b1, -1, 1'b0);
        load(1'b0, N_W, 2, -1, 1'b0, -1, 1'b1);
        load(1'b0, N_W, 0, -1, 1'b0, 70, 1'b0);
        load(1'b0, N_W, 0, -1, 1'b0, -1, 1'b0);
        load(1'b1, N_A, 2, -1, 1'b0, -1, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("strobe_total", 64'(strobes), 64'(expected_strobes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
